// File: rtl/uart_wb_sequencer.sv
// Wishbone master that programs a 16550-style UART, then services it by polling LSR.
// Define UART_SEQ_LOOPBACK_EN to add an MCR write (internal loopback) to the init sequence.
module uart_wb_sequencer #(
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  FCR_VAL  = 8'h06,
    parameter logic [7:0]  IER_VAL  = 8'h00,
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    input  logic       wb_ack_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       init_done,
    output logic       rx_overrun,
    output logic       bus_error,
    output logic [3:0] state_dbg
);

    // Byte streams: tx_data is held while tx_valid is high and is consumed on the
    // single-cycle tx_ready pulse; rx_data is valid while rx_valid is high and is
    // released on any cycle with rx_ready high.
    typedef enum logic [3:0] {
        INIT_LCRD,
        INIT_DLL,
        INIT_DLM,
        INIT_LCR,
`ifdef UART_SEQ_LOOPBACK_EN
        INIT_MCR,
`endif
        INIT_FCR,
        INIT_IER,
        GAP,
        POLL,
        RX_READ,
        TX_WRITE
    } state_t;

    localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  gap_cnt;
    logic [15:0] timer;
    logic        last_rx;
    logic [2:0]  acc_adr;
    logic [7:0]  acc_dat;
    logic        acc_we;
    logic        rx_ok;
    logic        tx_ok;

    assign state_dbg = state;
    assign rx_ok     = wb_dat_i[0] & ~rx_valid;
    assign tx_ok     = wb_dat_i[5] & tx_valid;

    // GAP decodes to the LSR read so the poll can launch on the cycle the gap ends.
    always_comb begin
        acc_adr = 3'd0;
        acc_dat = 8'h00;
        acc_we  = 1'b0;
        case (state)
            INIT_LCRD: begin acc_adr = 3'd3; acc_dat = LCR_VAL | 8'h80;  acc_we = 1'b1; end
            INIT_DLL:  begin acc_adr = 3'd0; acc_dat = DIVISOR[7:0];     acc_we = 1'b1; end
            INIT_DLM:  begin acc_adr = 3'd1; acc_dat = DIVISOR[15:8];    acc_we = 1'b1; end
            INIT_LCR:  begin acc_adr = 3'd3; acc_dat = LCR_VAL & 8'h7F;  acc_we = 1'b1; end
`ifdef UART_SEQ_LOOPBACK_EN
            INIT_MCR:  begin acc_adr = 3'd4; acc_dat = 8'h10;            acc_we = 1'b1; end
`endif
            INIT_FCR:  begin acc_adr = 3'd2; acc_dat = FCR_VAL;          acc_we = 1'b1; end
            INIT_IER:  begin acc_adr = 3'd1; acc_dat = IER_VAL;          acc_we = 1'b1; end
            GAP, POLL: acc_adr = 3'd5;
            TX_WRITE:  begin acc_adr = 3'd0; acc_dat = tx_data;          acc_we = 1'b1; end
            default:   acc_adr = 3'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= INIT_LCRD;
            wb_adr_o   <= 3'd0;
            wb_dat_o   <= 8'h00;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            tx_ready   <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            init_done  <= 1'b0;
            rx_overrun <= 1'b0;
            bus_error  <= 1'b0;
            last_rx    <= 1'b0;
            gap_cnt    <= 8'd0;
            timer      <= 16'd0;
        end else begin
            tx_ready <= 1'b0;
            if (rx_ready) rx_valid <= 1'b0;
            if (state == GAP) begin
                if (gap_cnt == GAP_LAST) begin
                    state    <= POLL;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_adr_o <= acc_adr;
                    wb_dat_o <= acc_dat;
                    wb_we_o  <= acc_we;
                    timer    <= 16'd0;
                end else begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
            end else if (!wb_cyc_o) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_adr_o <= acc_adr;
                wb_dat_o <= acc_dat;
                wb_we_o  <= acc_we;
                timer    <= 16'd0;
            end else if (wb_ack_i) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                gap_cnt  <= 8'd0;
                case (state)
                    INIT_LCRD: state <= INIT_DLL;
                    INIT_DLL:  state <= INIT_DLM;
                    INIT_DLM:  state <= INIT_LCR;
`ifdef UART_SEQ_LOOPBACK_EN
                    INIT_LCR:  state <= INIT_MCR;
                    INIT_MCR:  state <= INIT_FCR;
`else
                    INIT_LCR:  state <= INIT_FCR;
`endif
                    INIT_FCR:  state <= INIT_IER;
                    INIT_IER: begin
                        state     <= GAP;
                        init_done <= 1'b1;
                    end
                    POLL: begin
                        if (wb_dat_i[1]) rx_overrun <= 1'b1;
                        // When both sides are ready, the one not served last goes first.
                        if (rx_ok && (!tx_ok || !last_rx)) begin
                            state   <= RX_READ;
                            last_rx <= 1'b1;
                        end else if (tx_ok) begin
                            state   <= TX_WRITE;
                            last_rx <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                    RX_READ: begin
                        rx_data  <= wb_dat_i;
                        rx_valid <= 1'b1;
                        state    <= GAP;
                    end
                    TX_WRITE: begin
                        tx_ready <= 1'b1;
                        state    <= GAP;
                    end
                    default: state <= INIT_LCRD;
                endcase
            end else if (timer == TO_LAST) begin
                wb_cyc_o  <= 1'b0;
                wb_stb_o  <= 1'b0;
                bus_error <= 1'b1;
                init_done <= 1'b0;
                state     <= INIT_LCRD;
            end else begin
                timer <= timer + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Bench for uart_wb_sequencer: 1-cycle-ack Wishbone slave model, bus log, directed and random steps.
module tb_uart_wb_sequencer;
    localparam logic [15:0] DIV = 16'd27;
    localparam logic [7:0]  LCR = 8'h03;
    localparam logic [7:0]  FCR = 8'h06;
    localparam logic [7:0]  IER = 8'h00;
    localparam int          TMO = 255;

    logic       wb_clk_i  = 1'b0;
    logic       wb_rst_ni = 1'b0;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_ack_i;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       init_done;
    logic       rx_overrun;
    logic       bus_error;
    logic [3:0] state_dbg;

    logic [7:0]  lsr = 8'h00;
    logic [7:0]  rbr = 8'h00;
    logic        block_fcr = 1'b0;
    logic [11:0] bus_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  sent_q[$];
    logic [11:0] held = 12'h000;
    logic        held_v = 1'b0;
    logic        model_last_rx = 1'b0;
    int          stab_err = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    uart_wb_sequencer #(
        .DIVISOR(DIV), .LCR_VAL(LCR), .FCR_VAL(FCR), .IER_VAL(IER),
        .POLL_GAP(4), .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .init_done(init_done), .rx_overrun(rx_overrun), .bus_error(bus_error),
        .state_dbg(state_dbg)
    );

    // clock and reset
    always #5 wb_clk_i = ~wb_clk_i;

    // slave model: ack one cycle after strobe, optional hang on FCR writes
    assign wb_dat_i = (wb_adr_o == 3'd5) ? lsr : (wb_adr_o == 3'd0) ? rbr : 8'h00;

    always @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) wb_ack_i <= 1'b0;
        else wb_ack_i <= wb_cyc_o && wb_stb_o && !wb_ack_i &&
                         !(block_fcr && wb_we_o && wb_adr_o == 3'd2);
    end

    // bus log {we, adr, data} plus hold-stability monitor, sampled mid-cycle
    always @(negedge wb_clk_i) begin
        if (wb_cyc_o && wb_stb_o) begin
            if (held_v && held !== {wb_we_o, wb_adr_o, wb_dat_o}) stab_err++;
            if (wb_ack_i) bus_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : wb_dat_i});
            held   = {wb_we_o, wb_adr_o, wb_dat_o};
            held_v = !wb_ack_i;
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    function automatic logic [11:0] init_exp(input int i);
        logic [11:0] e;
        case (i)
            0:       e = {1'b1, 3'd3, LCR | 8'h80};
            1:       e = {1'b1, 3'd0, 8'(DIV % 256)};
            2:       e = {1'b1, 3'd1, 8'(DIV / 256)};
            3:       e = {1'b1, 3'd3, LCR & 8'h7F};
            4:       e = {1'b1, 3'd2, FCR};
            default: e = {1'b1, 3'd1, IER};
        endcase
        return e;
    endfunction

    function automatic int count_acc(input logic we, input logic [2:0] adr);
        int n = 0;
        foreach (bus_q[i]) if (bus_q[i][11] == we && bus_q[i][10:8] == adr) n++;
        return n;
    endfunction

    task automatic wait_init_and_check(input string tag);
        int lat = 0;
        while (!init_done && lat < 60) begin tick(); lat++; end
        check({tag, "_init_done"}, 32'(init_done), 1);
        check({tag, "_init_latency_le18"}, 32'(lat <= 18), 1);
        check({tag, "_init_count"}, 32'(bus_q.size()), 6);
        for (int i = 0; i < 6; i++)
            check({tag, "_init_write"}, 32'((i < bus_q.size()) ? bus_q[i] : 12'hFFF), 32'(init_exp(i)));
    endtask

    task automatic send_tx(input logic [7:0] b);
        int lat = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && lat < 60) begin tick(); lat++; end
        tx_valid = 1'b0;
        check("tx_ready_seen", 32'(tx_ready), 1);
        check("tx_latency_le13", 32'(lat <= 13), 1);
        exp_q.push_back(b);
        model_last_rx = 1'b0;
        tick();
        check("tx_ready_one_cycle", 32'(tx_ready), 0);
    endtask

    task automatic recv_rx(input logic [7:0] b);
        int w = 0;
        rbr = b;
        lsr = 8'h01;
        while (!rx_valid && w < 60) begin tick(); w++; end
        lsr = 8'h00;
        check("rx_valid_seen", 32'(rx_valid), 1);
        check("rx_data", 32'(rx_data), 32'(b));
        model_last_rx = 1'b1;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx_consumed", 32'(rx_valid), 0);
    endtask

    initial begin
        int k;
        int n0;
        int n5;
        logic [31:0] e;
        logic [11:0] op_q[$];
        logic first_tx;
        int t;

        // reset values
        repeat (3) tick();
        check("reset_bus", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 0);
        check("reset_status", 32'({tx_ready, rx_valid, rx_data, init_done, rx_overrun, bus_error}), 0);
        check("reset_state", 32'(state_dbg), 0);

        // init sequence
        wb_rst_ni = 1'b1;
        wait_init_and_check("first");

        // idle polling: LSR reads only
        bus_q.delete();
        repeat (30) tick();
        n5 = count_acc(1'b0, 3'd5);
        check("idle_polls_seen", 32'(n5 > 0), 1);
        check("idle_only_polls", 32'(bus_q.size() - n5), 0);

        // directed and random transmit
        bus_q.delete();
        lsr = 8'h60;
        send_tx(8'hA5);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 7)) tick();
            send_tx(8'($urandom));
        end
        lsr = 8'h00;
        repeat (10) tick();
        check("tx_write_count", 32'(count_acc(1'b1, 3'd0)), 32'(exp_q.size()));
        foreach (bus_q[i]) if (bus_q[i][11:8] == 4'b1000) begin
            if (exp_q.size() > 0) e = 32'(exp_q.pop_front());
            else e = 32'hFFFF_FFFF;
            check("tx_write_data", 32'(bus_q[i][7:0]), e);
        end

        // receive with backpressure
        rbr = 8'h3C;
        lsr = 8'h01;
        k = 0;
        while (!rx_valid && k < 60) begin tick(); k++; end
        check("bp_rx_valid", 32'(rx_valid), 1);
        check("bp_rx_data", 32'(rx_data), 32'h3C);
        n0 = count_acc(1'b0, 3'd0);
        n5 = count_acc(1'b0, 3'd5);
        repeat (40) tick();
        check("bp_no_extra_rbr_read", 32'(count_acc(1'b0, 3'd0) - n0), 0);
        check("bp_polls_continue", 32'(count_acc(1'b0, 3'd5) > n5), 1);
        check("bp_rx_valid_held", 32'(rx_valid), 1);
        lsr = 8'h00;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("bp_rx_released", 32'(rx_valid), 0);
        model_last_rx = 1'b1;

        // random receive, then one transmit so the last served side is TX
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 7)) tick();
            recv_rx(8'($urandom));
        end
        lsr = 8'h60;
        send_tx(8'($urandom));
        lsr = 8'h00;
        repeat (10) tick();
        check("no_overrun_yet", 32'(rx_overrun), 0);

        // fairness: both sides always ready
        bus_q.delete();
        sent_q.delete();
        first_tx = model_last_rx;
        rbr = 8'($urandom);
        rx_ready = 1'b1;
        tx_data = 8'($urandom);
        sent_q.push_back(tx_data);
        tx_valid = 1'b1;
        lsr = 8'h61;
        k = 0;
        while ((count_acc(1'b0, 3'd0) + count_acc(1'b1, 3'd0)) < 4 && k < 300) begin
            tick();
            k++;
            if (tx_ready) begin
                tx_data = 8'($urandom);
                sent_q.push_back(tx_data);
            end
        end
        tx_valid = 1'b0;
        lsr = 8'h00;
        repeat (20) tick();
        rx_ready = 1'b0;
        foreach (bus_q[i]) if (bus_q[i][10:8] == 3'd0) op_q.push_back(bus_q[i]);
        check("fair_access_count", 32'(op_q.size() >= 4), 1);
        t = 0;
        for (int j = 0; j < 4; j++) begin
            if (j < op_q.size()) begin
                check("fair_order", 32'(op_q[j][11]), 32'(first_tx ^ j[0]));
                if (op_q[j][11]) begin
                    check("fair_tx_data", 32'(op_q[j][7:0]), 32'((t < sent_q.size()) ? sent_q[t] : 8'hxx));
                    t++;
                end else begin
                    check("fair_rx_data", 32'(op_q[j][7:0]), 32'(rbr));
                end
            end
        end

        // overrun flag is sticky
        lsr = 8'h02;
        repeat (20) tick();
        lsr = 8'h00;
        repeat (20) tick();
        check("overrun_sticky", 32'(rx_overrun), 1);

        // asynchronous reset in the middle of a bus cycle
        k = 0;
        while (!wb_cyc_o && k < 30) begin tick(); k++; end
        check("cyc_before_reset", 32'(wb_cyc_o), 1);
        wb_rst_ni = 1'b0;
        #1;
        check("async_reset_bus", 32'({wb_cyc_o, wb_stb_o}), 0);
        check("async_reset_flags", 32'({rx_overrun, init_done, bus_error, rx_valid}), 0);

        // ack timeout on the FCR write
        block_fcr = 1'b1;
        bus_q.delete();
        tick();
        wb_rst_ni = 1'b1;
        k = 0;
        while (!(wb_cyc_o && wb_we_o && wb_adr_o == 3'd2) && k < 40) begin tick(); k++; end
        check("fcr_write_started", 32'(wb_cyc_o && wb_adr_o == 3'd2), 1);
        k = 0;
        while (wb_cyc_o && k < 400) begin tick(); k++; end
        check("timeout_cycles", 32'(k), 32'(TMO));
        check("timeout_bus_error", 32'(bus_error), 1);
        check("timeout_init_cleared", 32'(init_done), 0);
        check("timeout_cyc_low", 32'(wb_cyc_o), 0);
        block_fcr = 1'b0;
        bus_q.delete();
        wait_init_and_check("restart");
        check("bus_error_sticky", 32'(bus_error), 1);
        check("hold_stability", 32'(stab_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/uart_wb_sequencer.md
# uart_wb_sequencer

Wishbone bus master that owns the 16550-compatible `uart_top` slave port. After reset it programs the UART (divisor, line control, FIFO control, interrupt enable) and then services it by polling LSR. Received bytes go to a one-entry holding register with a valid/ready output. Transmit bytes from a valid/ready input are written to THR. It sits between the PicoBlaze-side byte streams and the UART, replacing ad-hoc Wishbone traffic with one scheduled master.

## Interface
- DIVISOR, 16'd27: baud divisor written to DLM:DLL (50 MHz / (16 × 115200)).
- LCR_VAL, 8'h03: line control, 8N1; bit 7 is ignored and forced by the sequencer.
- FCR_VAL, 8'h06: FIFO control written during init (clear RX/TX FIFOs).
- IER_VAL, 8'h00: interrupt enable written during init.
- POLL_GAP, 4: idle cycles between LSR polls; legal range 0–255.
- TIMEOUT, 255: cycles to wait for `wb_ack_i` before aborting; legal range 1–65535.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  reset, asynchronous and active-low.
- wb_adr_o  out  3  UART register address.
- wb_dat_o  out  8  write data.
- wb_dat_i  in  8  read data.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  slave acknowledge.
- tx_data  in  8  byte to send; held stable while tx_valid is high.
- tx_valid  in  1  a transmit byte is offered.
- tx_ready  out  1  one-cycle pulse when the byte has been written to THR.
- rx_data  out  8  received byte.
- rx_valid  out  1  holding register is full.
- rx_ready  in  1  consumer takes the byte.
- init_done  out  1  high once init completes.
- rx_overrun  out  1  sticky; set when LSR bit 1 (OE) is read as 1.
- bus_error  out  1  sticky; set on an ack timeout.

## Operation
- Register map: 0 = RBR/THR/DLL, 1 = IER/DLM, 2 = FCR, 3 = LCR, 4 = MCR, 5 = LSR.
- FSM states: INIT_LCRD, INIT_DLL, INIT_DLM, INIT_LCR, [INIT_MCR], INIT_FCR, INIT_IER, GAP, POLL, RX_READ, TX_WRITE.
- Init sequence, one write each:
  - INIT_LCRD writes LCR_VAL|8'h80.
  - INIT_DLL writes DIVISOR[7:0].
  - INIT_DLM writes DIVISOR[15:8].
  - INIT_LCR writes LCR_VAL&8'h7F.
  - INIT_FCR writes FCR_VAL; INIT_IER writes IER_VAL.
  - init_done then rises and the FSM enters GAP.
- GAP counts POLL_GAP cycles, then goes to POLL, which reads LSR (adr 5).
- Decision after the POLL ack:
  - rx_ok = LSR[0] & ~rx_valid.
  - tx_ok = LSR[5] & tx_valid.
  - Only rx_ok: go to RX_READ. Only tx_ok: go to TX_WRITE. Neither: go to GAP.
  - Both: serve the side not served last (`last_rx` flag); after reset RX wins.
- RX_READ reads adr 0. On ack, rx_data is loaded and rx_valid set. rx_valid clears on a cycle where rx_ready is high.
- TX_WRITE writes tx_data to adr 0. On ack, tx_ready pulses for exactly one cycle.
- After RX_READ or TX_WRITE the FSM goes to GAP.
- rx_overrun is set on any POLL ack with wb_dat_i[1]=1.
- Timeout: if an access waits TIMEOUT cycles without ack:
  - cyc and stb drop, bus_error is set, init_done clears.
  - The FSM restarts at INIT_LCRD. No tx_ready pulse and no rx_valid result from the aborted access.
- When tx_valid drops during a poll, the decision uses the tx_valid value in the ack cycle.

## Timing
- Reset values: all outputs 0 (wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, tx_ready, rx_data, rx_valid, init_done, rx_overrun, bus_error). The FSM resets to INIT_LCRD.
- Deassertion of wb_rst_ni is used directly; the first access starts on the first clock edge after deassertion.
- Bus outputs are registered. cyc, stb, adr, dat and we are stable from assertion until the ack is sampled.
- cyc/stb drop in the cycle after the edge that samples ack. There is at least one idle bus cycle between accesses.
- Ack latency: with a 1-cycle ack, each access occupies 2 cycles plus 1 idle. Init takes 6 accesses, so init_done rises ≤ 18 cycles after reset (21 with loopback).
- tx_ready and rx_valid assert in the cycle after the data-phase ack.
- Worst-case byte latency with POLL_GAP=4 and 1-cycle ack: tx_valid to tx_ready ≤ 4 + 3 + 3 + 3 cycles.
- An asynchronous reset during a bus cycle drops cyc/stb immediately.

## Configuration
- UART_SEQ_LOOPBACK_EN defined: INIT_MCR is inserted after INIT_LCR and writes MCR (adr 4) = 8'h10, which puts the UART in internal loopback.
- Undefined: the INIT_MCR state is absent and MCR is never written.

## Test plan
- Init: release reset with a 1-cycle-ack slave model.
  - Required writes, in order: (3,8'h83), (0,8'h1B), (1,8'h00), (3,8'h03), (2,8'h06), (1,8'h00).
  - init_done rises afterwards.
- TX: LSR=8'h60, tx_data=8'hA5, tx_valid=1.
  - Required: write (0,8'hA5), then a tx_ready pulse of exactly one cycle.
- RX with backpressure: LSR=8'h01, RBR=8'h3C, rx_ready=0.
  - Required: rx_data=8'h3C and rx_valid=1.
  - Further polls must not read adr 0 until rx_ready is pulsed.
- Fairness: LSR=8'h61 constant, tx_valid held with rx_ready=1.
  - Required order after POLL: RX_READ, TX_WRITE, RX_READ, TX_WRITE.
- Timeout: the slave never acks the INIT_FCR write.
  - Required: after 255 cycles cyc=0 and bus_error=1, and the sequence restarts with the write (3,8'h83).
- Loopback with UART_SEQ_LOOPBACK_EN against the real uart_top: write (4,8'h10) during init; tx_data=8'h5A returns as rx_data=8'h5A.
